// File: rtl/pfu_if_stage_pkg.sv
// -----------------------------------------------------------------------------
// pfu_if_stage_pkg
//   Shared constants for the program-fetch unit: PC-source select encodings,
//   select width, default reset PC, fetch step/link offsets, the IF/ID nop
//   word, the redirect FSM state type and immediate extension helpers.
//   Imported by pfu_target_gen and pfu_if_stage.
// -----------------------------------------------------------------------------
package pfu_if_stage_pkg;

  localparam int PFU_OP_LENGTH = 3;

  localparam logic [31:0] PFU_RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PFU_PC_STEP          = 32'd4;
  localparam logic [31:0] PFU_LINK_OFFSET      = 32'd8;
  localparam logic [31:0] PFU_INSTR_NOP        = 32'h0000_0000;

  // PC source for the instruction currently in ID.
  typedef enum logic [PFU_OP_LENGTH-1:0] {
    PFU_OP_NEXT      = 3'd0,
    PFU_OP_OFFSET_16 = 3'd1,
    PFU_OP_OFFSET_26 = 3'd2,
    PFU_OP_JUMP      = 3'd3,
    PFU_OP_RS        = 3'd4
  } pfu_op_e;

  // Redirect state: RUN fetches sequentially or redirects at once,
  // WAIT_SLOT holds a taken target until the delay slot has been fetched.
  typedef enum logic {
    PFU_ST_RUN       = 1'b0,
    PFU_ST_WAIT_SLOT = 1'b1
  } pfu_state_e;

  // Sign-extended 16-bit word offset converted to a byte offset.
  function automatic logic [31:0] sext16_x4(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // Sign-extended 26-bit word offset converted to a byte offset.
  function automatic logic [31:0] sext26_x4(input logic [25:0] imm);
    return {{4{imm[25]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pfu_target_gen.sv
// -----------------------------------------------------------------------------
// pfu_target_gen
//   Combinational branch/jump target generator working on the IF/ID contents.
//   Ports:
//     id_pc    in   32        PC of the instruction in ID
//     id_instr in   32        instruction word in ID
//     rs_data  in   32        forwarded rs value (register-indirect target)
//     pfu_op   in   PFU_OP_W  PC-source select
//     target   out  32        redirect target (id_pc+4 when pfu_op is NEXT)
// -----------------------------------------------------------------------------
module pfu_target_gen
  import pfu_if_stage_pkg::*;
#(
  parameter int PFU_OP_W = PFU_OP_LENGTH
) (
  input  logic [31:0]         id_pc,
  input  logic [31:0]         id_instr,
  input  logic [31:0]         rs_data,
  input  logic [PFU_OP_W-1:0] pfu_op,
  output logic [31:0]         target
);

  // All relative targets are computed from the delay-slot address.
  logic [31:0] base;
  assign base = id_pc + PFU_PC_STEP;

  // Opcode bits are not needed to form a target.
  logic unused_opcode;
  assign unused_opcode = ^id_instr[31:26];

  always_comb begin
    target = base;
    case (pfu_op)
      PFU_OP_W'(PFU_OP_OFFSET_16): target = base + sext16_x4(id_instr[15:0]);
      PFU_OP_W'(PFU_OP_OFFSET_26): target = base + sext26_x4(id_instr[25:0]);
      PFU_OP_W'(PFU_OP_JUMP):      target = {base[31:28], id_instr[25:0], 2'b00};
      // Register-indirect targets are used unmodified, even if misaligned.
      PFU_OP_W'(PFU_OP_RS):        target = rs_data;
      default:                     target = base;
    endcase
  end

endmodule

// File: rtl/pfu_if_stage.sv
// -----------------------------------------------------------------------------
// pfu_if_stage
//   Program-fetch unit plus IF/ID pipeline register with one architectural
//   branch delay slot. Holds the PC, drives the instruction-memory address and
//   registers each fetched word with its PC for the ID stage.
//   Ports:
//     clk           in   1         system clock, rising edge
//     reset         in   1         asynchronous active-high reset
//     stall         in   1         freeze PC, IF/ID and redirect state
//     pfu_op        in   PFU_OP_W  PC source for the instruction in ID
//     rs_data       in   32        forwarded rs value (jr/jalr target)
//     imem_addr     out  32        fetch address (= pc_q)
//     imem_rdata    in   32        instruction word at imem_addr
//     imem_ready    in   1         imem_rdata valid this cycle
//     id_instr      out  32        IF/ID instruction, 0 when id_valid=0
//     id_pc         out  32        IF/ID PC
//     id_pc_plus8   out  32        id_pc+8 link value
//     id_valid      out  1         IF/ID holds a real instruction
//     redir_pending out  1         taken redirect waiting for its delay slot
// -----------------------------------------------------------------------------
module pfu_if_stage
  import pfu_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PFU_RESET_PC_DEFAULT,
  parameter int          PFU_OP_W = PFU_OP_LENGTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [PFU_OP_W-1:0] pfu_op,
  input  logic [31:0]         rs_data,
  output logic [31:0]         imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ready,
  output logic [31:0]         id_instr,
  output logic [31:0]         id_pc,
  output logic [31:0]         id_pc_plus8,
  output logic                id_valid,
  output logic                redir_pending
);

  logic [31:0] pc_q,           pc_d;
  logic [31:0] id_instr_q,     id_instr_d;
  logic [31:0] id_pc_q,        id_pc_d;
  logic        id_valid_q,     id_valid_d;
  logic [31:0] redir_target_q, redir_target_d;
  pfu_state_e  state_q,        state_d;

  logic [31:0] target;
  logic        take;

  pfu_target_gen #(
    .PFU_OP_W (PFU_OP_W)
  ) u_target_gen (
    .id_pc    (id_pc_q),
    .id_instr (id_instr_q),
    .rs_data  (rs_data),
    .pfu_op   (pfu_op),
    .target   (target)
  );

  // pfu_op is only trusted when ID holds a real instruction and the pipe
  // advances; under stall its operands may be stale.
  assign take = id_valid_q & ~stall & (pfu_op != PFU_OP_W'(PFU_OP_NEXT));

  always_comb begin
    pc_d           = pc_q;
    id_instr_d     = id_instr_q;
    id_pc_d        = id_pc_q;
    id_valid_d     = id_valid_q;
    redir_target_d = redir_target_q;
    state_d        = state_q;

    if (!stall) begin
      if (imem_ready) begin
        // The word fetched now is the delay slot whenever a redirect is
        // being taken or is already pending.
        id_instr_d = imem_rdata;
        id_pc_d    = pc_q;
        id_valid_d = 1'b1;
        if (state_q == PFU_ST_WAIT_SLOT) begin
          pc_d = redir_target_q;
        end else if (take) begin
          pc_d = target;
        end else begin
          pc_d = pc_q + PFU_PC_STEP;
        end
        state_d = PFU_ST_RUN;
      end else begin
        // Fetch not ready: insert a bubble and keep fetching the slot
        // address; a taken target is parked until the slot arrives.
        id_instr_d = PFU_INSTR_NOP;
        id_valid_d = 1'b0;
        if (take) begin
          state_d        = PFU_ST_WAIT_SLOT;
          redir_target_d = target;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      id_instr_q     <= PFU_INSTR_NOP;
      id_pc_q        <= RESET_PC;
      id_valid_q     <= 1'b0;
      redir_target_q <= 32'h0000_0000;
      state_q        <= PFU_ST_RUN;
    end else begin
      pc_q           <= pc_d;
      id_instr_q     <= id_instr_d;
      id_pc_q        <= id_pc_d;
      id_valid_q     <= id_valid_d;
      redir_target_q <= redir_target_d;
      state_q        <= state_d;
    end
  end

  assign imem_addr     = pc_q;
  assign id_instr      = id_instr_q;
  assign id_pc         = id_pc_q;
  assign id_pc_plus8   = id_pc_q + PFU_LINK_OFFSET;
  assign id_valid      = id_valid_q;
  assign redir_pending = (state_q == PFU_ST_WAIT_SLOT);

endmodule

// File: tb/tb_pfu_if_stage.sv
// -----------------------------------------------------------------------------
// tb_pfu_if_stage
//   Directed scenarios plus randomized traffic for pfu_if_stage, compared
//   every cycle against a behavioural fetch/delay-slot model.
// -----------------------------------------------------------------------------
module tb_pfu_if_stage;
  import pfu_if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  pfu_op;
  logic [31:0] rs_data;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus8;
  logic        id_valid;
  logic        redir_pending;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_idpc;
  bit          m_valid;
  bit          m_slot;      // ID word is a delay slot
  logic [31:0] m_pend[$];   // parked redirect targets (at most one)

  pfu_if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .pfu_op        (pfu_op),
    .rs_data       (rs_data),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc_plus8   (id_pc_plus8),
    .id_valid      (id_valid),
    .redir_pending (redir_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_target(input logic [2:0] op, input logic [31:0] pc,
                                             input logic [31:0] instr, input logic [31:0] rs);
    logic [31:0] nxt;
    nxt = pc + 32'd4;
    case (op)
      3'd1:    return nxt + 32'($signed(instr[15:0])) * 32'd4;
      3'd2:    return nxt + 32'($signed(instr[25:0])) * 32'd4;
      3'd3:    return (nxt & 32'hF000_0000) + 32'(instr[25:0]) * 32'd4;
      3'd4:    return rs;
      default: return nxt;
    endcase
  endfunction

  task automatic model_reset();
    m_pc    = 32'h0000_3000;
    m_instr = 32'h0;
    m_idpc  = 32'h0000_3000;
    m_valid = 1'b0;
    m_slot  = 1'b0;
    m_pend.delete();
  endtask

  task automatic compare_all(input string w);
    chk({w, ".imem_addr"},     imem_addr,     m_pc);
    chk({w, ".id_instr"},      id_instr,      m_instr);
    chk({w, ".id_pc"},         id_pc,         m_idpc);
    chk({w, ".id_pc_plus8"},   id_pc_plus8,   m_idpc + 32'd8);
    chk({w, ".id_valid"},      32'(id_valid), 32'(m_valid));
    chk({w, ".redir_pending"}, 32'(redir_pending), 32'(m_pend.size() != 0));
    chk({w, ".pend_implies_novalid"}, 32'(redir_pending & id_valid), 32'd0);
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input string w, input bit s, input logic [2:0] op,
                      input logic [31:0] rs, input logic [31:0] word, input bit rdy);
    bit          take;
    bit          had;
    logic [31:0] t;
    stall = s; pfu_op = op; rs_data = rs; imem_rdata = word; imem_ready = rdy;
    if (!s) begin
      take = m_valid && (op != 3'd0);
      t    = ref_target(op, m_idpc, m_instr, rs);
      if (rdy) begin
        had     = (m_pend.size() != 0);
        m_idpc  = m_pc;
        m_instr = word;
        m_valid = 1'b1;
        if (had)       m_pc = m_pend.pop_front();
        else if (take) m_pc = t;
        else           m_pc = m_pc + 32'd4;
        m_slot = take || had;
      end else begin
        m_instr = 32'h0;
        m_valid = 1'b0;
        m_slot  = 1'b0;
        if (take) m_pend.push_back(t);
      end
    end
    @(posedge clk);
    #1;
    compare_all(w);
  endtask

  task automatic do_reset();
    stall = 0; pfu_op = 0; rs_data = 0; imem_rdata = 0; imem_ready = 0;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    compare_all("reset");
    reset = 1'b0;
  endtask

  initial begin
    bit          s, rdy;
    logic [2:0]  op;
    logic [31:0] rs;

    reset = 1'b1;
    stall = 0; pfu_op = 0; rs_data = 0; imem_rdata = 0; imem_ready = 0;

    // Sequential fetch from reset
    do_reset();
    chk("reset_addr", imem_addr, 32'h3000);
    step("seq0", 0, 3'd0, 0, 32'h11, 1);
    chk("seq_first_instr", id_instr, 32'h11);
    chk("seq_first_pc", id_pc, 32'h3000);
    chk("seq_first_plus8", id_pc_plus8, 32'h3008);
    chk("seq_first_valid", 32'(id_valid), 32'd1);
    step("seq1", 0, 3'd0, 0, 32'h22, 1);
    step("seq2", 0, 3'd0, 0, 32'h33, 1);
    chk("seq_addr", imem_addr, 32'h300C);
    step("seq3", 0, 3'd0, 0, 32'h0, 1);
    step("seq4", 0, 3'd0, 0, 32'h1000_FFFC, 1);   // beq at 0x3010

    // Taken backward branch, slot ready at once
    step("br_rdy", 0, 3'd1, 0, 32'hAAAA_0001, 1);
    chk("br_rdy_slot_pc", id_pc, 32'h3014);
    chk("br_rdy_target", imem_addr, 32'h3004);

    // Same branch with the slot fetch delayed two cycles
    do_reset();
    step("pw0", 0, 3'd0, 0, 32'h11, 1);
    step("pw1", 0, 3'd0, 0, 32'h22, 1);
    step("pw2", 0, 3'd0, 0, 32'h33, 1);
    step("pw3", 0, 3'd0, 0, 32'h0, 1);
    step("pw4", 0, 3'd0, 0, 32'h1000_FFFC, 1);
    step("pw_wait0", 0, 3'd1, 0, 32'hDEAD_BEEF, 0);
    chk("pw_pending", 32'(redir_pending), 32'd1);
    chk("pw_valid", 32'(id_valid), 32'd0);
    chk("pw_addr", imem_addr, 32'h3014);
    step("pw_wait1", 0, 3'd0, 0, 32'hDEAD_BEEF, 0);
    chk("pw_addr_hold", imem_addr, 32'h3014);
    step("pw_slot", 0, 3'd0, 0, 32'h5107_5107, 1);
    chk("pw_slot_pc", id_pc, 32'h3014);
    chk("pw_target", imem_addr, 32'h3004);
    chk("pw_cleared", 32'(redir_pending), 32'd0);

    // Stall freezes everything and masks pfu_op
    do_reset();
    step("st0", 0, 3'd0, 0, 32'h0000_0008, 1);
    for (int i = 0; i < 3; i++) begin
      step("st_hold", 1, 3'd4, 32'h4000, $urandom, 1);
      chk("st_addr", imem_addr, 32'h3004);
      chk("st_idpc", id_pc, 32'h3000);
    end
    step("st_go", 0, 3'd4, 32'h4000, 32'h7777_0000, 1);
    chk("st_target", imem_addr, 32'h4000);

    // Absolute jump
    do_reset();
    step("jal0", 0, 3'd0, 0, 32'h0C00_0C10, 1);
    step("jal_slot", 0, 3'd3, 0, 32'h0, 1);
    chk("jal_target", imem_addr, 32'h0000_3040);

    // PC wrap-around
    do_reset();
    step("wr0", 0, 3'd0, 0, 32'h1, 1);
    step("wr_slot", 0, 3'd4, 32'hFFFF_FFFC, 32'h2, 1);
    step("wr_top", 0, 3'd0, 0, 32'h3, 1);
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset while a redirect is pending
    do_reset();
    step("rp0", 0, 3'd0, 0, 32'h11, 1);
    step("rp_wait", 0, 3'd4, 32'h8000, 32'h0, 0);
    chk("rp_pending", 32'(redir_pending), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rp_async_pending", 32'(redir_pending), 32'd0);
    chk("rp_async_addr", imem_addr, 32'h3000);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    compare_all("rp_release");
    chk("rp_release_valid", 32'(id_valid), 32'd0);
    step("rp_first", 0, 3'd0, 0, 32'h99, 1);
    chk("rp_first_pc", id_pc, 32'h3000);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      s   = ($urandom_range(0, 4) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      if (s || !m_valid) op = 3'($urandom_range(0, 4));
      else if (!m_slot && $urandom_range(0, 1) == 1) op = 3'($urandom_range(1, 4));
      else op = 3'd0;
      rs = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : {$urandom, 2'b00} >> 2 << 2;
      step("rand", s, op, rs, $urandom, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pfu_if_stage.md
Name: pfu_if_stage

Overview:
- Program-fetch unit plus IF/ID pipeline register. It holds the PC, drives the instruction-memory address, and registers each fetched word and its PC for the ID stage.
- It consumes the ID-stage control outputs: the PC-source select (pfu_op) and the stall request.
- Branches resolve in ID with one architectural delay slot, so a redirect never flushes the slot instruction.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset.
- PFU_OP_W, `PFU_OP_LENGTH (3), width of the PC-source select.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- stall  in  1  pause request from ID control; freezes PC, IF/ID and pending state.
- pfu_op  in  PFU_OP_W  PC source for the instruction now in ID: NEXT, OFFSET_16, OFFSET_26, JUMP, RS.
- rs_data  in  32  forwarded rs value of the ID instruction (jr/jalr target).
- imem_addr  out  32  fetch address; always equals pc_q (combinational).
- imem_rdata  in  32  instruction word at imem_addr.
- imem_ready  in  1  imem_rdata valid this cycle.
- id_instr  out  32  IF/ID instruction; 0 (nop) when id_valid=0.
- id_pc  out  32  IF/ID PC.
- id_pc_plus8  out  32  id_pc+8, used as the link value.
- id_valid  out  1  IF/ID holds a real instruction.
- redir_pending  out  1  a taken redirect is waiting for its delay slot to be fetched.

Behaviour:
- Reset values (async):
  - pc_q = RESET_PC.
  - id_instr = 0, id_pc = RESET_PC, id_valid = 0.
  - redir_pending = 0, redir_target = 0.
- Target computation, combinational, from ID contents, mod 2^32:
  - base = id_pc+4.
  - OFFSET_16: base + (sext(id_instr[15:0])<<2).
  - OFFSET_26: base + (sext(id_instr[25:0])<<2).
  - JUMP: {base[31:28], id_instr[25:0], 2'b00}.
  - RS: rs_data, used as-is with no alignment check.
- take = id_valid & ~stall & (pfu_op != NEXT).
- stall=1: pc_q, IF/ID, redir_pending and redir_target all hold. imem_rdata is discarded. pfu_op is ignored, because its operands may be stale.
- stall=0, imem_ready=1:
  - IF/ID <= {imem_rdata, pc_q, valid=1}; this word is the delay slot when take=1.
  - pc_q <= redir_pending ? redir_target : take ? target : pc_q+4.
  - redir_pending <= 0.
- stall=0, imem_ready=0:
  - IF/ID <= bubble {instr 0, pc unchanged, valid 0}; pc_q holds.
  - If take: redir_pending <= 1 and redir_target <= target.
  - The slot is still fetched from pc_q before the target.
- Invariant: redir_pending=1 implies id_valid=0, so take and a pending redirect are never simultaneous. The bench asserts this.
- A branch in a delay slot is unsupported and the behaviour is undefined.
- Latency: fetch to ID is 1 cycle. A taken branch in ID at cycle n puts the target in IF at n+1 (slot ready) or after the slot's ready cycle (pending).
- PC wraps 32'hFFFF_FFFC -> 0 with no flag.
- Reset asserted mid-operation clears a pending redirect immediately. The first fetch after reset release is RESET_PC.
- FSM is implicit in redir_pending: RUN (0) and WAIT_SLOT (1).
  - RUN -> WAIT_SLOT on take & ~imem_ready & ~stall.
  - WAIT_SLOT -> RUN on imem_ready & ~stall.

Decomposition:
- Shared const.vh holds the PFU_OP_* encodings, PFU_OP_LENGTH and the RESET_PC default. No new constants are defined locally.
- One combinational sub-module, pfu_target_gen (id_pc, id_instr, rs_data, pfu_op -> target). The PC/IF-ID registers and pending logic stay in pfu_if_stage.

Test Plan:
- Reset, then imem_ready=1 with words 0x11,0x22,0x33 -> imem_addr 0x3000,0x3004,0x3008; id_instr 0x11 at cycle 1 with id_pc 0x3000, id_pc_plus8 0x3008, id_valid=1.
- beq in ID at id_pc 0x3010, imm16=0xFFFC, pfu_op=OFFSET_16, ready=1 -> slot 0x3014 fetched; next imem_addr 0x3004.
- Same branch with imem_ready=0 for 2 cycles:
  - redir_pending=1, id_valid=0 and imem_addr=0x3014 during the wait.
  - On ready, the slot enters ID and the next imem_addr is 0x3004.
- stall=1 for 3 cycles with pfu_op=RS, rs_data=0x4000 -> pc_q, id_* and redir_pending unchanged; redirect taken only on the first unstalled cycle.
- jal at id_pc 0x3000, instr[25:0]=0x0000C10, pfu_op=JUMP -> after the slot, imem_addr 0x0000_3040.
- Reset asserted while redir_pending=1 -> pending cleared asynchronously; after release, imem_addr=0x3000 and id_valid=0.
